bk_subtractor_pipe: RTL and testbench
=====================================

// Module: bk_subtractor_pipe
// PURPOSE
//   Pipelined WIDTH-bit Brent-Kung prefix subtractor. It computes diff = a - b - bin as a + ~b + ~bin.
//   It reuses the pre/black/grey/post cell structure of the combinational prefix adders.
//   Three register stages sit behind a valid/ready handshake. It feeds the ALU datapath and the
//   adder self-check bench, which compares its result against the adder's.
// PARAMETERS
//   WIDTH  16  operand width; power of 2, 4..64
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      operands a/b/bin valid this cycle
//   in_ready     out  1      stage 1 can accept operands
//   a            in   WIDTH  minuend
//   b            in   WIDTH  subtrahend
//   bin          in   1      borrow in (1 = subtract one extra)
//   out_valid    out  1      result valid
//   out_ready    in   1      consumer accepts result
//   diff         out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout         out  1      borrow out: 1 when unsigned a < b + bin
//   ovf          out  1      signed overflow
//   zero         out  1      diff == 0
// BEHAVIOUR
//   Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
//   Reset values:
//     - s1_v, s2_v, s3_v = 0, so out_valid = 0.
//     - All data regs = 0, so diff = 0, bout = 0, ovf = 0, zero = 0 while out_valid = 0.
//   Reset mid-operation: all in-flight results are discarded; there is no partial output.
//   Stage 1 (pre), per bit i:
//     - bb = ~b[i]; p[i] = a[i]^bb; g[i] = a[i]&bb.
//     - Carry-in g_lsb = ~bin, p_lsb = 0.
//     - Also registers the signs a[W-1] and b[W-1].
//   Stage 2 (up-sweep):
//     - log2(WIDTH) levels of black cells; the grey cell merges into the lsb chain.
//     - Registers the group (G,P) at the Brent-Kung tree nodes plus the pass-through p.
//   Stage 3 (down-sweep + post):
//     - log2(WIDTH)-1 grey levels produce the carry into every bit.
//     - diff[i] = p[i] ^ c[i].
//     - carry_out = g[W-1] | p[W-1]&c[W-1]; bout = ~carry_out.
//     - ovf = (sa != sb) && (diff[W-1] != sa), where sa/sb are the signs of a and b.
//     - zero = ~|diff. All outputs are registered.
//   Latency: an accepted operand appears on out_valid exactly 3 cycles later when out_ready stays 1.
//   Throughput: 1 result per cycle.
//   Handshake:
//     - Transfer happens on in_valid&in_ready and on out_valid&out_ready.
//     - adv3 = ~s3_v | out_ready
//     - adv2 = ~s2_v | adv3
//     - adv1 = ~s1_v | adv2
//     - in_ready = adv1, combinational from out_ready; there is no skid buffer.
//   Stall:
//     - While out_valid & ~out_ready, the result regs and out_valid hold stable.
//     - Upstream bubbles still collapse, so up to 3 results can be buffered.
//   Boundary conditions:
//     - Simultaneous accept and drain on a full pipe is legal and keeps 1/cycle.
//     - in_valid while in_ready = 0: the inputs are ignored, and the source must hold them.
//     - Stage regs load only when their adv is high and the upstream valid bit is set;
//       each valid bit clears when it drains and no new data arrives.
//     - Wrap-around: 0 - 1 gives diff = all ones, bout = 1.
//     - Carry chain: no X propagation for any input combination.
// TESTING
//   1. Reset: hold rst_n = 0 with random inputs -> out_valid = 0, diff = 0, in_ready = 1;
//      release, then a=0x1234, b=0x0234, bin=0 -> after 3 clk: diff=0x1000, bout=0, zero=0.
//   2. Wrap/borrow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1;
//      then a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
//   3. Overflow/zero: a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0;
//      a=0xABCD, b=0xABCD, bin=0 -> zero=1, ovf=0.
//   4. Back-pressure: stream 8 operands with out_ready = 0 ->
//      in_ready drops after 3 accepts, out_valid and diff stay stable;
//      release -> all 8 results arrive in order with none lost or duplicated.
//   5. Throughput and reset mid-stream:
//      - out_ready = 1 with 1000 random back-to-back operands
//        -> 1 result/cycle, all matching the reference model a - b - bin.
//      - Assert rst_n mid-stream -> out_valid drops to 0 immediately, and no stale result appears afterwards.
//   6. Width sweep: WIDTH = 4 exhaustive (all a, b, bin) and WIDTH = 32 random
//      -> diff, bout, ovf, zero match the model.

Source files
------------

// File: rtl/bk_subtractor_pipe.sv
// Three-stage pipelined Brent-Kung prefix subtractor: diff = a + ~b + ~bin.
// Stage 1 forms bitwise (g,p), stage 2 runs the up-sweep, stage 3 the down-sweep and sum.
module bk_subtractor_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int LOG = $clog2(WIDTH);

    // Handshake: a stage advances when it is empty or the stage after it advances.
    // Transfers happen on in_valid & in_ready and on out_valid & out_ready.
    logic w_adv1, w_adv2, w_adv3;

    logic             r_s1_v, r_s1_cin, r_s1_sa, r_s1_sb;
    logic [WIDTH-1:0] r_s1_g, r_s1_p;

    logic             r_s2_v, r_s2_cin, r_s2_sa, r_s2_sb;
    logic [WIDTH-1:0] r_s2_gg, r_s2_gp, r_s2_p;

    logic             r_s3_v, r_bout, r_ovf, r_zero;
    logic [WIDTH-1:0] r_diff;

    logic [WIDTH-1:0] w_up_g, w_up_p, w_dn_g, w_c, w_diff;
    logic             w_cout, w_ovf;

    assign w_adv3   = ~r_s3_v | out_ready;
    assign w_adv2   = ~r_s2_v | w_adv3;
    assign w_adv1   = ~r_s1_v | w_adv2;
    assign in_ready = w_adv1;

    assign out_valid = r_s3_v;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_g   <= '0;
            r_s1_p   <= '0;
            r_s1_cin <= 1'b0;
            r_s1_sa  <= 1'b0;
            r_s1_sb  <= 1'b0;
        end else begin
            if (w_adv1) r_s1_v <= in_valid;
            if (w_adv1 && in_valid) begin
                r_s1_g   <= a & ~b;
                r_s1_p   <= a ^ ~b;
                r_s1_cin <= ~bin;
                r_s1_sa  <= a[WIDTH-1];
                r_s1_sb  <= b[WIDTH-1];
            end
        end
    end

    // Carry-in is folded into bit 0 first, so every group touching bit 0 has P = 0.
    always_comb begin : up_sweep
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g    = r_s1_g;
        p    = r_s1_p;
        g[0] = r_s1_g[0] | (r_s1_p[0] & r_s1_cin);
        p[0] = 1'b0;
        for (int l = 0; l < LOG; l++) begin
            for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                p[i] = p[i] & p[i - (1 << l)];
            end
        end
        w_up_g = g;
        w_up_p = p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v   <= 1'b0;
            r_s2_gg  <= '0;
            r_s2_gp  <= '0;
            r_s2_p   <= '0;
            r_s2_cin <= 1'b0;
            r_s2_sa  <= 1'b0;
            r_s2_sb  <= 1'b0;
        end else begin
            if (w_adv2) r_s2_v <= r_s1_v;
            if (w_adv2 && r_s1_v) begin
                r_s2_gg  <= w_up_g;
                r_s2_gp  <= w_up_p;
                r_s2_p   <= r_s1_p;
                r_s2_cin <= r_s1_cin;
                r_s2_sa  <= r_s1_sa;
                r_s2_sb  <= r_s1_sb;
            end
        end
    end

    // Down-sweep grey cells fill in the prefixes the up-sweep left partial.
    always_comb begin : down_sweep
        logic [WIDTH-1:0] g;
        g = r_s2_gg;
        for (int l = LOG - 2; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
                g[i] = g[i] | (r_s2_gp[i] & g[i - (1 << l)]);
            end
        end
        w_dn_g = g;
    end

    assign w_c    = {w_dn_g[WIDTH-2:0], r_s2_cin};
    assign w_diff = r_s2_p ^ w_c;
    assign w_cout = w_dn_g[WIDTH-1];
    assign w_ovf  = (r_s2_sa != r_s2_sb) && (w_diff[WIDTH-1] != r_s2_sa);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_v <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (w_adv3) r_s3_v <= r_s2_v;
            if (w_adv3 && r_s2_v) begin
                r_diff <= w_diff;
                r_bout <= ~w_cout;
                r_ovf  <= w_ovf;
                r_zero <= ~|w_diff;
            end
        end
    end

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Bench for bk_subtractor_pipe: WIDTH=16 main instance plus WIDTH=4 and WIDTH=32 sweep instances,
// checked against an arithmetic reference model through expected-result queues.
module tb_bk_subtractor_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, bin, out_valid, out_ready, bout, ovf, zero;
    logic [15:0] a, b, diff;

    logic        w4_in_valid, w4_in_ready, w4_bin, w4_out_valid, w4_bout, w4_ovf, w4_zero;
    logic [3:0]  w4_a, w4_b, w4_diff;
    logic        w32_in_valid, w32_in_ready, w32_bin, w32_out_valid, w32_bout, w32_ovf, w32_zero;
    logic [31:0] w32_a, w32_b, w32_diff;

    int checks = 0;
    int errors = 0;
    int results = 0;
    logic [18:0] exp_q[$];
    logic [6:0]  q4[$];
    logic [34:0] q32[$];

    bk_subtractor_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    bk_subtractor_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .bin(w4_bin), .out_valid(w4_out_valid), .out_ready(1'b1),
        .diff(w4_diff), .bout(w4_bout), .ovf(w4_ovf), .zero(w4_zero)
    );

    bk_subtractor_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w32_in_valid), .in_ready(w32_in_ready),
        .a(w32_a), .b(w32_b), .bin(w32_bin), .out_valid(w32_out_valid), .out_ready(1'b1),
        .diff(w32_diff), .bout(w32_bout), .ovf(w32_ovf), .zero(w32_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {diff[63:0], bout, ovf, zero} for a w-bit subtraction.
    function automatic logic [66:0] model(int w, logic [63:0] x, logic [63:0] y, logic bi);
        logic [63:0] m;
        logic [64:0] full;
        logic [63:0] d;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        full = {1'b0, x & m} - {1'b0, y & m} - {64'd0, bi};
        d    = full[63:0] & m;
        return {d, full[w], (x[w-1] != y[w-1]) && (d[w-1] != x[w-1]), d == 64'd0};
    endfunction

    // One cycle on the 16-bit instance: drive, record accepts, score any delivered result.
    task automatic step(input logic v, input logic [15:0] xa, input logic [15:0] xb,
                        input logic xbin, input logic ordy,
                        output logic took, output logic ov, output logic [18:0] og);
        logic [66:0] m;
        logic [18:0] e;
        in_valid  = v;
        a         = xa;
        b         = xb;
        bin       = xbin;
        out_ready = ordy;
        #1;
        took = v && in_ready;
        ov   = out_valid;
        og   = {diff, bout, ovf, zero};
        if (took) begin
            m = model(16, {48'd0, xa}, {48'd0, xb}, xbin);
            exp_q.push_back(m[18:0]);
        end
        if (out_valid && ordy) begin
            results++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected got %h with empty queue", og);
            end else begin
                e = exp_q.pop_front();
                if (og !== e) begin
                    errors++;
                    $display("FAIL scoreboard_result got %h expected %h", og, e);
                end
            end
        end
        @(negedge clk);
    endtask

    // Send one operand set into an empty pipe and return the observed result.
    task automatic run_one(input logic [15:0] xa, input logic [15:0] xb, input logic xbin,
                           output logic [18:0] got);
        logic took, ov, found;
        logic [18:0] og;
        took  = 1'b0;
        found = 1'b0;
        got   = '0;
        for (int k = 0; k < 10 && !took; k++) step(1'b1, xa, xb, xbin, 1'b1, took, ov, og);
        for (int k = 0; k < 10 && !found; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, took, ov, og);
            if (ov) begin
                found = 1'b1;
                got   = og;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL run_one_timeout got no out_valid expected one result");
        end
    endtask

    task automatic test_reset();
        logic took, ov;
        logic [18:0] og;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = 16'($urandom);
            b         = 16'($urandom);
            bin       = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid got %b expected 0", out_valid);
            end
            checks++;
            if ({diff, bout, ovf, zero} !== 19'd0) begin
                errors++;
                $display("FAIL reset_data got %h expected 0", {diff, bout, ovf, zero});
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready got %b expected 1", in_ready);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        step(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b1, took, ov, og);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, took, ov, og);
            checks++;
            if (ov !== (k == 3)) begin
                errors++;
                $display("FAIL latency_cycle%0d got out_valid=%b expected %b", k, ov, k == 3);
            end
        end
        checks++;
        if (og !== {16'h1000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL first_result got %h expected %h", og, {16'h1000, 3'b000});
        end
    endtask

    task automatic test_wrap_borrow();
        logic [18:0] got;
        run_one(16'h0000, 16'h0001, 1'b0, got);
        checks++;
        if (got !== {16'hFFFF, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_0_minus_1 got %h expected %h", got, {16'hFFFF, 3'b100});
        end
        run_one(16'h0005, 16'h0005, 1'b1, got);
        checks++;
        if (got !== {16'hFFFF, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL borrow_in got %h expected %h", got, {16'hFFFF, 3'b100});
        end
    endtask

    task automatic test_ovf_zero();
        logic [18:0] got;
        run_one(16'h8000, 16'h0001, 1'b0, got);
        checks++;
        if (got !== {16'h7FFF, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL signed_ovf got %h expected %h", got, {16'h7FFF, 3'b010});
        end
        run_one(16'hABCD, 16'hABCD, 1'b0, got);
        checks++;
        if (got !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL zero_flag got %h expected %h", got, {16'h0000, 3'b001});
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] oa[8];
        logic [15:0] ob[8];
        logic        obi[8];
        logic        took, ov, have;
        logic [18:0] og, snap;
        int idx, base;
        for (int k = 0; k < 8; k++) begin
            oa[k]  = 16'($urandom);
            ob[k]  = 16'($urandom);
            obi[k] = 1'($urandom_range(0, 1));
        end
        idx  = 0;
        have = 1'b0;
        snap = '0;
        base = results;
        for (int k = 0; k < 8; k++) begin
            step(idx < 8, oa[idx % 8], ob[idx % 8], obi[idx % 8], 1'b0, took, ov, og);
            if (took) idx++;
            if (ov) begin
                if (!have) begin
                    snap = og;
                    have = 1'b1;
                end else begin
                    checks++;
                    if (og !== snap) begin
                        errors++;
                        $display("FAIL stall_hold got %h expected %h", og, snap);
                    end
                end
            end
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL stall_accepts got %0d expected 3", idx);
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_flags got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
        end
        for (int k = 0; k < 40 && (idx < 8 || exp_q.size() > 0); k++) begin
            step(idx < 8, oa[idx % 8], ob[idx % 8], obi[idx % 8], 1'b1, took, ov, og);
            if (took) idx++;
        end
        checks++;
        if (results - base != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_count got %0d results %0d pending expected 8 0",
                     results - base, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic took, ov;
        logic [18:0] og;
        int base, gaps, refused;
        base    = results;
        gaps    = 0;
        refused = 0;
        for (int k = 0; k < 1000; k++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, took, ov, og);
            if (!took) refused++;
            if (k >= 3 && !ov) gaps++;
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, took, ov, og);
        checks++;
        if (gaps != 0 || refused != 0) begin
            errors++;
            $display("FAIL throughput got gaps=%0d refused=%0d expected 0 0", gaps, refused);
        end
        checks++;
        if (results - base != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count got %0d pending %0d expected 1000 0",
                     results - base, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic took, ov;
        logic [18:0] og, got;
        int stale;
        for (int k = 0; k < 20; k++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, took, ov, og);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out_valid got %b expected 0", out_valid);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, took, ov, og);
            if (ov) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midreset_stale got %0d results expected 0", stale);
        end
        run_one(16'h0010, 16'h0001, 1'b1, got);
        checks++;
        if (got !== {16'h000E, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_recover got %h expected %h", got, {16'h000E, 3'b000});
        end
    endtask

    // Drives both sweep instances for one cycle and scores their outputs.
    task automatic step_w(input logic v, input logic [3:0] x4, input logic [3:0] y4, input logic b4,
                          input logic [31:0] x32, input logic [31:0] y32, input logic b32,
                          output int got4, output int got32);
        logic [66:0] m;
        logic [6:0]  e4;
        logic [34:0] e32;
        w4_in_valid  = v;  w4_a  = x4;  w4_b  = y4;  w4_bin  = b4;
        w32_in_valid = v;  w32_a = x32; w32_b = y32; w32_bin = b32;
        #1;
        got4  = 0;
        got32 = 0;
        if (v) begin
            checks++;
            if (w4_in_ready !== 1'b1 || w32_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_in_ready got %b %b expected 1 1", w4_in_ready, w32_in_ready);
            end
            m = model(4, {60'd0, x4}, {60'd0, y4}, b4);
            q4.push_back(m[6:0]);
            m = model(32, {32'd0, x32}, {32'd0, y32}, b32);
            q32.push_back(m[34:0]);
        end
        if (w4_out_valid) begin
            got4 = 1;
            checks++;
            e4 = (q4.size() > 0) ? q4.pop_front() : 7'hxx;
            if ({w4_diff, w4_bout, w4_ovf, w4_zero} !== e4) begin
                errors++;
                $display("FAIL w4_result got %h expected %h", {w4_diff, w4_bout, w4_ovf, w4_zero}, e4);
            end
        end
        if (w32_out_valid) begin
            got32 = 1;
            checks++;
            e32 = (q32.size() > 0) ? q32.pop_front() : 35'hx;
            if ({w32_diff, w32_bout, w32_ovf, w32_zero} !== e32) begin
                errors++;
                $display("FAIL w32_result got %h expected %h",
                         {w32_diff, w32_bout, w32_ovf, w32_zero}, e32);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_width_sweep();
        int n4, n32, g4, g32;
        logic [8:0] k9;
        n4  = 0;
        n32 = 0;
        for (int k = 0; k < 512; k++) begin
            k9 = 9'(k);
            step_w(1'b1, k9[3:0], k9[7:4], k9[8], $urandom, $urandom, 1'($urandom_range(0, 1)), g4, g32);
            n4  += g4;
            n32 += g32;
        end
        for (int k = 0; k < 10 && (q4.size() > 0 || q32.size() > 0); k++) begin
            step_w(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, g4, g32);
            n4  += g4;
            n32 += g32;
        end
        checks++;
        if (n4 != 512 || n32 != 512 || q4.size() != 0 || q32.size() != 0) begin
            errors++;
            $display("FAIL sweep_count got %0d %0d pending %0d %0d expected 512 512 0 0",
                     n4, n32, q4.size(), q32.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_bin = 1'b0;
        w32_in_valid = 1'b0; w32_a = '0; w32_b = '0; w32_bin = 1'b0;
        @(negedge clk);
        test_reset();
        test_wrap_borrow();
        test_ovf_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_width_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
